secded_stream_decoder: RTL

Parametrised, pipelined single-error-correct / double-error-detect (extended Hamming) decoder for a streaming data path. It generalises our fixed 32-bit single-error-correcting combinational checker to any data width, adds double-error detection, valid/ready flow control and saturating error-statistics counters. It sits between a memory or link read port and its consumer.

---
 rtl/secded_stream_decoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/secded_stream_decoder.sv
// Pipelined extended-Hamming (SECDED) decoder with valid/ready flow control
// and saturating single/double error statistics counters.
module secded_stream_decoder #(
   parameter int DATA_W = 32,
   parameter int CHK_W  = 7,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CHK_W-1:0]  in_chk,
   input  logic              corr_en,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_sec,
   output logic              out_ded,
   output logic [CHK_W-2:0]  out_syn,
   output logic [CNT_W-1:0]  sec_cnt,
   output logic [CNT_W-1:0]  ded_cnt,
   input  logic              cnt_clr
);

   localparam int SYN_W = CHK_W - 1;
   localparam int N     = DATA_W + CHK_W - 1;
   localparam logic [SYN_W-1:0] N_SYN = SYN_W'(N);

   if ((DATA_W < 4) || ((2 ** (CHK_W - 1)) < (DATA_W + CHK_W))) begin : g_bad_cfg
      $error("secded_stream_decoder: CHK_W too small for DATA_W");
   end

   // Codeword position of data bit idx: the idx-th non-power-of-two position.
   function automatic int data_pos(input int idx);
      int pos;
      int cnt;
      pos = 0;
      cnt = -1;
      while (cnt < idx) begin
         pos = pos + 1;
         if ((pos & (pos - 1)) != 0) cnt = cnt + 1;
      end
      return pos;
   endfunction

   logic                 s1_valid_reg;
   logic [SYN_W-1:0]     s1_syn_reg;
   logic                 s1_par_reg;
   logic [DATA_W-1:0]    s1_data_reg;
   logic                 s1_corr_reg;

   logic                 out_valid_reg;
   logic [DATA_W-1:0]    out_data_reg;
   logic                 out_sec_reg;
   logic                 out_ded_reg;
   logic [SYN_W-1:0]     out_syn_reg;

   logic [CNT_W-1:0]     sec_cnt_reg, sec_cnt_next;
   logic [CNT_W-1:0]     ded_cnt_reg, ded_cnt_next;

   logic [SYN_W-1:0]     data_term [DATA_W];
   logic [DATA_W-1:0]    flip_mask;
   logic [SYN_W-1:0]     syn_next;
   logic                 par_next;
   logic                 sec_next;
   logic                 ded_next;
   logic                 s1_load;
   logic                 s2_load;
   logic                 out_hs;

   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
      localparam logic [SYN_W-1:0] POS = SYN_W'(data_pos(gi));
      assign data_term[gi] = in_data[gi] ? POS : '0;
      assign flip_mask[gi] = s1_corr_reg & s1_par_reg & (s1_syn_reg == POS);
   end

   // Check bit k sits at position 2^k, so it contributes exactly syndrome bit k.
   always_comb begin
      syn_next = in_chk[SYN_W-1:0];
      for (int i = 0; i < DATA_W; i++) begin
         syn_next = syn_next ^ data_term[i];
      end
      par_next = ^{in_data, in_chk};
   end

   assign sec_next = s1_par_reg & (s1_syn_reg <= N_SYN);
   assign ded_next = s1_par_reg ? (s1_syn_reg > N_SYN) : (s1_syn_reg != '0);

   assign s2_load  = !out_valid_reg | out_ready;
   assign s1_load  = !s1_valid_reg | s2_load;
   assign in_ready = s1_load;
   assign out_hs   = out_valid_reg & out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s1_syn_reg   <= '0;
         s1_par_reg   <= 1'b0;
         s1_data_reg  <= '0;
         s1_corr_reg  <= 1'b0;
      end else if (s1_load) begin
         s1_valid_reg <= in_valid;
         if (in_valid) begin
            s1_syn_reg  <= syn_next;
            s1_par_reg  <= par_next;
            s1_data_reg <= in_data;
            s1_corr_reg <= corr_en;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_sec_reg   <= 1'b0;
         out_ded_reg   <= 1'b0;
         out_syn_reg   <= '0;
      end else if (s2_load) begin
         out_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            out_data_reg <= s1_data_reg ^ flip_mask;
            out_sec_reg  <= sec_next;
            out_ded_reg  <= ded_next;
            out_syn_reg  <= s1_syn_reg;
         end
      end
   end

   // Clear beats a coincident increment; counters stick at all-ones.
   always_comb begin
      sec_cnt_next = sec_cnt_reg;
      ded_cnt_next = ded_cnt_reg;
      if (cnt_clr) begin
         sec_cnt_next = '0;
         ded_cnt_next = '0;
      end else begin
         if (out_hs && out_sec_reg && (sec_cnt_reg != '1)) sec_cnt_next = sec_cnt_reg + CNT_W'(1);
         if (out_hs && out_ded_reg && (ded_cnt_reg != '1)) ded_cnt_next = ded_cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sec_cnt_reg <= '0;
         ded_cnt_reg <= '0;
      end else begin
         sec_cnt_reg <= sec_cnt_next;
         ded_cnt_reg <= ded_cnt_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_sec   = out_sec_reg;
   assign out_ded   = out_ded_reg;
   assign out_syn   = out_syn_reg;
   assign sec_cnt   = sec_cnt_reg;
   assign ded_cnt   = ded_cnt_reg;

endmodule
